muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit that answers mul/div issue requests from the EX stage of the 5-stage core. The pipeline holds EX while the unit is busy and releases on the `mul_done`/`div_done` pulses. The unit computes MUL/MULH/MULHSU/MULHU with radix-2 shift-add and DIV/DIVU/REM/REMU with restoring division. Divide-by-zero and signed overflow take a 2-cycle fast path.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is verified.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `start  in  1`: issue request. Sampled only in IDLE; ignored otherwise.
- `flush  in  1`: kill the in-flight operation. Beats `start` in the same cycle.
- `op  in  3`: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU. `op[2]`=1 means divide.
- `rs1  in  32`: multiplicand or dividend, sampled with `start`.
- `rs2  in  32`: multiplier or divisor, sampled with `start`.
- `busy  out  1`: high from the cycle after an accepted `start` through the FIN cycle.
- `mul_done  out  1`: one-cycle pulse in FIN when the operation is a multiply.
- `div_done  out  1`: one-cycle pulse in FIN when the operation is a divide.
- `result  out  32`: registered result. Valid in FIN and held until the next accepted `start` or `rst`.

## Operation
- States:
  - IDLE: waits for a request.
  - PREP: latches operand signs, takes absolute values of signed operands, and detects special cases.
  - RUN: 32 iterations; 6-bit counter counts 0..31.
  - FIN: applies sign correction, writes `result`, pulses done.
- Transitions:
  - IDLE→PREP on `start`; `op`/`rs1`/`rs2` are captured into internal registers.
  - PREP→FIN when a special case is detected, otherwise PREP→RUN.
  - RUN→FIN when the counter reaches 31.
  - FIN→IDLE unconditionally.
- Multiply:
  - 64-bit product register. Each RUN cycle adds the multiplicand when the multiplier LSB is 1, then shifts right.
  - Signedness: MUL and MULH treat both operands as signed. MULHSU treats `rs1` as signed and `rs2` as unsigned. MULHU treats both as unsigned.
  - Product is negated in FIN when the operand signs differ (signed operands only).
  - MUL returns product[31:0]; the other three return product[63:32].
- Divide:
  - 33-bit partial remainder; quotient is shifted in one bit per RUN cycle.
  - Signed results follow RISC-V rules: quotient sign = sign(rs1)^sign(rs2), remainder sign = sign(rs1), truncation toward zero.
- Special cases, resolved in PREP:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- `flush` or `rst` in any state goes to IDLE at the next edge. No done pulse is produced and `busy` drops. On `flush`, `result` keeps its last value.
- `start` is asserted together with `flush` in IDLE: the flush wins and no request is accepted.
- `start` while `busy`: ignored; captured operands are not disturbed.
- Back-to-back requests: `start` may be asserted again in the cycle after FIN (state is IDLE).

## Timing
- `start` sampled at edge E0:
  - Normal path: PREP in cycle 1, RUN in cycles 2–33, FIN in cycle 34. Done pulse and valid `result` appear in cycle 34.
  - Special-case path: FIN in cycle 2. Done pulse appears in cycle 2.
- `busy` is high in cycles 1..34 (normal) or 1..2 (special-case), and low in IDLE.
- `mul_done` and `div_done` are never high together and are high for exactly 1 cycle per completed operation.
- Reset values: state IDLE, counter 0, `busy`=0, `mul_done`=0, `div_done`=0, `result`=0x00000000.
- All outputs are registered or decoded from state only. There is no combinational path from `start`/`rs1`/`rs2` to any output.

## Structure
- Shared package `muldiv_pkg`:
  - op encoding localparams (`OP_MUL`..`OP_REMU`).
  - state encoding (`S_IDLE`, `S_PREP`, `S_RUN`, `S_FIN`).
  - the constants `ITER=32`, `DIV0_Q=32'hFFFFFFFF` and `INT_MIN=32'h80000000`.
- One sub-module: `muldiv_signfix`. It is combinational: it takes the raw 64-bit product or the quotient/remainder, `op` and the sign flags, and returns the corrected 32-bit result. The FSM and iteration datapath stay in `muldiv_unit`.

## Test plan
- MUL 7 × 0xFFFFFFFD → `result`=0xFFFFFFEB and `mul_done`=1 exactly in cycle 34. Then MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE, and MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD with `div_done` in cycle 34. REM of the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14 and REMU 100 / 7 → 2.
- Divide-by-zero fast path:
  - DIVU 5 / 0 → 0xFFFFFFFF in cycle 2.
  - REM 5 / 0 → 5.
- Signed overflow fast path:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 2.
  - REM of the same operands → 0.
- Flush and busy behaviour:
  - `flush` in cycle 10 of a MUL: `busy`=0 in cycle 11, no done pulse, `result` unchanged.
  - `start` with new operands in cycle 5 of a DIV: ignored, and the original DIV result still appears in cycle 34.
- `rst` asserted in cycle 20 of a DIVU: all outputs return to their reset values at the next edge. A new MUL 3 × 4 issued afterwards → 0x0000000C in cycle 34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam int          ITER    = 32;
  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Issue/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            mul_done;
  logic            div_done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, op, rs1, rs2,
                  input  busy, mul_done, div_done, result);
  modport slave  (input  start, flush, op, rs1, rs2,
                  output busy, mul_done, div_done, result);
endinterface

// File: rtl/muldiv_signfix.sv
// Turns the unsigned magnitude produced by the iteration into the final
// RV32M result: optional negation, then high/low half or quotient/remainder.
import muldiv_pkg::*;

module muldiv_signfix #(parameter int XLEN = 32) (
  input  logic [2*XLEN-1:0] raw,      // product, or quotient in the low half
  input  logic [XLEN-1:0]   rem,
  input  logic [2:0]        op,
  input  logic              neg_res,  // product / quotient must be negated
  input  logic              neg_rem,  // remainder must be negated
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] prod_fix;

  // Select and sign-correct the result for the requested operation.
  always_comb begin
    prod_fix = neg_res ? -raw : raw;
    result   = '0;
    case (op)
      OP_MUL:                       result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = neg_res ? -raw[XLEN-1:0] : raw[XLEN-1:0];
      default:                      result = neg_rem ? -rem : rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, 32 iterations, with a fast path for div-by-zero/overflow.
//
// state  | meaning
// IDLE   | waiting for start; operands captured when it arrives
// PREP   | take magnitudes, record signs, detect special cases
// RUN    | one multiply/divide step per cycle, cnt 0..31
// FIN    | result valid, done pulse for the operation class
import muldiv_pkg::*;

module muldiv_unit #(parameter int XLEN = 32) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod;      // product; low half doubles as quotient/dividend
  logic [XLEN-1:0]   rem;
  logic [5:0]        cnt;
  logic              neg_res, neg_rem;
  logic [XLEN-1:0]   result_q;

  logic              is_div, sgn_a, sgn_b, is_div0, is_ovf;
  logic [XLEN-1:0]   abs_a, abs_b, spec_val;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_nxt;
  logic [2*XLEN-1:0] prod_nxt;
  logic [XLEN-1:0]   fixed;

  // Operand preparation and special-case detection from captured operands.
  always_comb begin
    is_div   = op_q[2];
    sgn_a    = a_q[XLEN-1] && (op_q != OP_MULHU) && (op_q != OP_DIVU) && (op_q != OP_REMU);
    sgn_b    = b_q[XLEN-1] && (op_q inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    abs_a    = sgn_a ? -a_q : a_q;
    abs_b    = sgn_b ? -b_q : b_q;
    is_div0  = is_div && (b_q == '0);
    is_ovf   = (op_q == OP_DIV || op_q == OP_REM) && (a_q == INT_MIN) && (b_q == '1);
    spec_val = '0;
    if (is_div0)     spec_val = op_q[1] ? a_q : DIV0_Q;
    else if (is_ovf) spec_val = op_q[1] ? '0 : INT_MIN;
  end

  // One iteration step: add-and-shift for multiply, shift-and-subtract for divide.
  always_comb begin
    mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    rem_sh  = {rem, prod[XLEN-1]};
    rem_ge  = rem_sh >= {1'b0, opnd};
    rem_nxt = rem_ge ? XLEN'(rem_sh - {1'b0, opnd}) : rem_sh[XLEN-1:0];
    if (is_div) prod_nxt = {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], rem_ge};
    else        prod_nxt = {mul_sum, prod[XLEN-1:1]};
  end

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .raw     (prod_nxt),
    .rem     (rem_nxt),
    .op      (op_q),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .result  (fixed)
  );

  // Control FSM and iteration datapath; result is written on entry to FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd     <= '0;
      prod     <= '0;
      rem      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          op_q  <= bus.op;
          a_q   <= bus.rs1;
          b_q   <= bus.rs2;
          state <= S_PREP;
        end
        S_PREP: begin
          cnt     <= '0;
          rem     <= '0;
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= sgn_a;
          if (is_div) begin
            opnd <= abs_b;
            prod <= {{XLEN{1'b0}}, abs_a};
          end else begin
            opnd <= abs_a;
            prod <= {{XLEN{1'b0}}, abs_b};
          end
          if (is_div0 || is_ovf) begin
            result_q <= spec_val;
            state    <= S_FIN;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          prod <= prod_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt + 6'd1;
          if (cnt == LAST_CNT) begin
            result_q <= fixed;
            cnt      <= '0;
            state    <= S_FIN;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.mul_done = (state == S_FIN) && !op_q[2];
  assign bus.div_done = (state == S_FIN) &&  op_q[2];
  assign bus.result   = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue
// time and checked when the done pulse appears.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_if bus ();

  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        scb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_res = 32'h0;

  int          obs_cyc;
  logic [31:0] obs_res;
  logic        obs_md, obs_dd, obs_busy_ok, obs_tail;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] x, y, p;
    logic signed [31:0] sa, sb;
    logic        [63:0] u;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin u = {32'h0, a} * {32'h0, b}; return u[31:0]; end
      3'd1: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
      3'd2: begin x = {{32{a[31]}}, a}; y = {32'h0, b}; p = x * y; return p[63:32]; end
      3'd3: begin u = {32'h0, a} * {32'h0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && b == 0) return 2;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Drives start at the current negedge; returns at mid-cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want);
    exp_t e;
    e.op = op; e.res = want; e.lat = model_lat(op, a, b);
    scb.push_back(e);
    bus.start = 1'b1; bus.op = op; bus.rs1 = a; bus.rs2 = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for a done pulse starting at mid-cycle c0; leaves us at
  // the negedge of the cycle after FIN.
  task automatic collect(input int c0);
    int cyc;
    cyc = c0;
    obs_cyc = -1; obs_res = 'x; obs_md = 1'b0; obs_dd = 1'b0;
    obs_busy_ok = 1'b1; obs_tail = 1'b0;
    while (cyc <= 40) begin
      if (bus.busy !== 1'b1) obs_busy_ok = 1'b0;
      if (bus.mul_done === 1'b1 || bus.div_done === 1'b1) begin
        obs_cyc = cyc; obs_res = bus.result; obs_md = bus.mul_done; obs_dd = bus.div_done;
        @(negedge clk);
        obs_tail = bus.busy | bus.mul_done | bus.div_done;
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.rs1 = '0; bus.rs2 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.mul_done, bus.div_done} !== 3'b000 || bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy/md/dd=%b%b%b result=%h want 000 00000000",
               bus.busy, bus.mul_done, bus.div_done, bus.result);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  // Issues a table of operations with directed expected values.
  task automatic test_arith();
    logic [2:0]  ops [10] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd2, 3'd5, 3'd6};
    logic [31:0] as  [10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                              32'd100, 32'd100, 32'hFFFFFFFF, 32'd5, 32'd5};
    logic [31:0] bs  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] ws  [10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'd14, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5};
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], ws[i]);
      collect(1);
      e = scb.pop_front();
      last_res = e.res;
      n_cmp++;
      if (obs_cyc !== e.lat) begin
        n_err++; $display("FAIL arith[%0d] latency: got %0d want %0d", i, obs_cyc, e.lat);
      end
      n_cmp++;
      if (obs_res !== e.res) begin
        n_err++; $display("FAIL arith[%0d] result: got %h want %h", i, obs_res, e.res);
      end
      n_cmp++;
      if ({obs_md, obs_dd} !== (e.op[2] ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL arith[%0d] done_kind: got md/dd=%b%b", i, obs_md, obs_dd);
      end
      n_cmp++;
      if (obs_busy_ok !== 1'b1 || obs_tail !== 1'b0) begin
        n_err++;
        $display("FAIL arith[%0d] busy_window: got busy_ok=%b tail=%b want 1 0", i, obs_busy_ok, obs_tail);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [3] = '{3'd4, 3'd6, 3'd7};
    logic [31:0] ws  [3] = '{32'h80000000, 32'h0, 32'h80000000};
    logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'h80000000, bs[i], ws[i]);
      collect(1);
      e = scb.pop_front();
      last_res = e.res;
      n_cmp++;
      if (obs_cyc !== 2 || obs_cyc !== e.lat) begin
        n_err++; $display("FAIL special[%0d] latency: got %0d want 2", i, obs_cyc);
      end
      n_cmp++;
      if (obs_res !== e.res || obs_dd !== 1'b1 || obs_md !== 1'b0) begin
        n_err++;
        $display("FAIL special[%0d] result: got %h md/dd=%b%b want %h 01", i, obs_res, obs_md, obs_dd, e.res);
      end
    end
  endtask

  task automatic test_flush();
    logic seen;
    issue(3'd0, 32'd123, 32'd456, model(3'd0, 32'd123, 32'd456));
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    void'(scb.pop_front());
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL flush_busy: got %b want 0", bus.busy);
    end
    seen = 1'b0;
    repeat (30) begin
      if (bus.mul_done === 1'b1 || bus.div_done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++; $display("FAIL flush_no_done: got activity=%b want 0", seen);
    end
    n_cmp++;
    if (bus.result !== last_res) begin
      n_err++; $display("FAIL flush_result_hold: got %h want %h", bus.result, last_res);
    end
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd5; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL flush_beats_start: got busy=%b want 0", bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    issue(3'd4, 32'hFFFFFF00, 32'd7, model(3'd4, 32'hFFFFFF00, 32'd7));
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd2; bus.rs2 = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    collect(6);
    e = scb.pop_front();
    last_res = e.res;
    n_cmp++;
    if (obs_cyc !== 34 || obs_res !== e.res || obs_dd !== 1'b1) begin
      n_err++;
      $display("FAIL start_while_busy: got cyc=%0d res=%h dd=%b want 34 %h 1", obs_cyc, obs_res, obs_dd, e.res);
    end
    n_cmp++;
    if (obs_tail !== 1'b0) begin
      n_err++; $display("FAIL start_while_busy_tail: got %b want 0", obs_tail);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    issue(3'd5, 32'd1000, 32'd3, model(3'd5, 32'd1000, 32'd3));
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(scb.pop_front());
    last_res = 32'h0;
    n_cmp++;
    if ({bus.busy, bus.mul_done, bus.div_done} !== 3'b000 || bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL mid_reset: got busy/md/dd=%b%b%b result=%h want 000 00000000",
               bus.busy, bus.mul_done, bus.div_done, bus.result);
    end
    issue(3'd0, 32'd3, 32'd4, 32'h0000000C);
    collect(1);
    e = scb.pop_front();
    last_res = e.res;
    n_cmp++;
    if (obs_cyc !== 34 || obs_res !== e.res || obs_md !== 1'b1) begin
      n_err++;
      $display("FAIL after_reset_mul: got cyc=%0d res=%h md=%b want 34 %h 1", obs_cyc, obs_res, obs_md, e.res);
    end
  endtask

  // Random operations issued in the cycle right after each FIN.
  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a, b;
    exp_t        e;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 5 == 0) ? 32'h0 : $urandom;
      if (i % 7 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 4 == 1) b = b >> $urandom_range(0, 31);
      issue(op, a, b, model(op, a, b));
      collect(1);
      e = scb.pop_front();
      last_res = e.res;
      n_cmp++;
      if (obs_cyc !== e.lat || obs_res !== e.res) begin
        n_err++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got cyc=%0d res=%h want %0d %h",
                 i, op, a, b, obs_cyc, obs_res, e.lat, e.res);
      end
      n_cmp++;
      if ({obs_md, obs_dd} !== (op[2] ? 2'b01 : 2'b10) || obs_tail !== 1'b0) begin
        n_err++;
        $display("FAIL b2b[%0d] done_pulse: got md/dd=%b%b tail=%b", i, obs_md, obs_dd, obs_tail);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_flush();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
